demux_vc: RTL and testbench
===========================

Name: demux_vc

Overview:
- 1:2 demultiplexer: the receive-side counterpart of the registered 2:1 channel mux in the PCIe QoS TC/VC path.
- Takes a single stream of 6-bit words and routes each word to one of two virtual-channel outputs. The route is chosen by a class bit carried in the word itself.
- Each output has its own small FIFO, so one stalled channel does not block traffic already buffered for the other.
- Valid/ready handshake on the input and on both outputs.

Parameters:
- DATA_WIDTH, 6, width of data_in, data_out0 and data_out1.
- DEPTH, 4, entries per channel FIFO; must be a power of 2 and at least 2.
- SEL_BIT, 5, bit index of data_in that selects the output (0 selects channel 0, 1 selects channel 1).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  incoming word.
- valid_in  input  1  data_in is valid this cycle.
- ready_out  output  1  input accept; combinational, equals !full[data_in[SEL_BIT]].
- data_out0  output  DATA_WIDTH  head word of the channel-0 FIFO.
- valid_out0  output  1  channel-0 FIFO not empty.
- ready_in0  input  1  downstream consumer accepts channel 0.
- data_out1  output  DATA_WIDTH  head word of the channel-1 FIFO.
- valid_out1  output  1  channel-1 FIFO not empty.
- ready_in1  input  1  downstream consumer accepts channel 1.
- count0  output  log2(DEPTH)+1  channel-0 occupancy.
- count1  output  log2(DEPTH)+1  channel-1 occupancy.

Behaviour:
- Reset (asserted at any time, effective immediately without waiting for clk):
  - all FIFO pointers, count0 and count1 go to 0.
  - valid_out0, valid_out1, data_out0 and data_out1 go to 0.
  - Storage contents are don't-care, but data_outN must read 0 while its FIFO is empty.
  - Reset in the middle of traffic discards all buffered words.
- Routing: sel = data_in[SEL_BIT]. The full word, including the select bit, is stored unmodified.
- Push: a push to channel sel happens when valid_in && ready_out at a clk edge.
- Pop: a pop from channel N happens when valid_outN && ready_inN at a clk edge.
- FIFOs are first-word-fall-through with registered storage.
- Latency: a word accepted at edge k appears on data_outN/valid_outN after edge k (visible in cycle k+1) if that FIFO was empty. There is no combinational path from data_in to data_outN.
- Ordering: strict FIFO order within each channel. No ordering relation between channels.
- Count update per channel: count += push − pop. Simultaneous push and pop on the same channel leaves count unchanged and advances both pointers.
- Full boundary:
  - full = (count == DEPTH). ready_out uses full only, so a full channel refuses a push even if it is popping in the same cycle (no bypass).
  - A word for a full channel is held by the sender; the other channel is unaffected.
- Empty boundary:
  - valid_outN = 0 and data_outN = 0.
  - ready_inN is ignored and no pop occurs; count never underflows.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
- Pushes to one channel and pops from the other are independent and may coincide in the same cycle.
- ready_inN may toggle freely. valid_outN must never drop without a pop.

Test Plan:
- Reset mid-stream: load 3 words into channel 0, assert reset between edges → count0, valid_out0 and data_out0 read 0 immediately (before the next clk edge); after release, the first new word appears 1 cycle after acceptance.
- Routing: push 0x05, 0x25, 0x0A, 0x3F with ready_in0 = ready_in1 = 1 → channel 0 outputs 0x05, 0x0A and channel 1 outputs 0x25, 0x3F, each 1 cycle after acceptance, in order.
- Full channel 0: ready_in0 = 0, push 4 words with bit 5 = 0 → count0 = 4 and ready_out = 0 for a fifth bit5 = 0 word; presenting 0x20 instead gives ready_out = 1 and it lands in channel 1.
- Push and pop at full: channel 0 full, ready_in0 = 1, valid_in with bit5 = 0 → pop occurs, push is refused that cycle, count0 = 3; the push is accepted on the next edge, count0 = 4.
- Simultaneous push/pop, non-full: count1 = 2, push to channel 1 and pop channel 1 on the same edge → count1 stays 2, data order preserved.
- Wrap-around: stream 12 words through channel 1 with random ready_in1 → all 12 words emerge in order, none lost or duplicated, and count1 never exceeds 4.

Source files
------------

// File: rtl/demux_vc.sv
// ---------------------------------------------------------------------------
// demux_vc
//   Receive-side 1:2 virtual-channel demultiplexer. A single valid/ready
//   stream of words is split across two channels. Bit SEL_BIT of each word
//   picks the channel. Each channel owns a first-word-fall-through FIFO, so
//   a stalled consumer on one channel never blocks words already buffered
//   for the other channel.
//
//   Ports
//     clk          clock, all state updates on the rising edge
//     reset        asynchronous, active-high; discards all buffered words
//     data_in      incoming word (stored unmodified, select bit included)
//     valid_in     data_in is valid this cycle
//     ready_out    combinational accept: the selected channel is not full
//     data_out0/1  head word of channel 0/1 FIFO, reads 0 while empty
//     valid_out0/1 channel 0/1 FIFO not empty
//     ready_in0/1  downstream accept for channel 0/1
//     count0/1     channel 0/1 occupancy
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// demux_vc_fifo
//   Single-channel FWFT FIFO with registered storage. The head entry drives
//   data_o directly from the storage array, so a word written at edge k is
//   visible right after that edge. A full FIFO refuses a push even when it
//   pops in the same cycle (no bypass); an empty FIFO ignores pop requests.
//
//   Ports
//     clk, reset   clock and asynchronous active-high reset
//     push_i       write data_i this edge (ignored while full)
//     pop_i        drop the head entry this edge (ignored while empty)
//     data_i       word to write
//     data_o       head word, forced to 0 while empty
//     valid_o      FIFO holds at least one word
//     full_o       occupancy equals DEPTH
//     count_o      occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module demux_vc_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  output logic [DATA_WIDTH-1:0]      data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic empty;
  logic full;
  logic push_ok;
  logic pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are exactly log2(DEPTH) bits, so they wrap DEPTH-1 -> 0 on
    // their own.
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset: its contents are masked by the empty check below.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign valid_o = !empty;
  assign full_o  = full;
  assign count_o = count_q;

endmodule

module demux_vc #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 4,
  parameter int SEL_BIT    = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  output logic [DATA_WIDTH-1:0]      data_out0,
  output logic                       valid_out0,
  input  logic                       ready_in0,
  output logic [DATA_WIDTH-1:0]      data_out1,
  output logic                       valid_out1,
  input  logic                       ready_in1,
  output logic [$clog2(DEPTH):0]     count0,
  output logic [$clog2(DEPTH):0]     count1
);

  logic sel;
  logic full0;
  logic full1;
  logic push0;
  logic push1;
  logic pop0;
  logic pop1;

  assign sel = data_in[SEL_BIT];

  // Accept depends only on the selected channel's full flag; a full channel
  // stalls the sender even if that channel is being drained this cycle.
  assign ready_out = sel ? !full1 : !full0;

  assign push0 = valid_in && ready_out && !sel;
  assign push1 = valid_in && ready_out &&  sel;
  assign pop0  = valid_out0 && ready_in0;
  assign pop1  = valid_out1 && ready_in1;

  demux_vc_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo0 (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push0),
    .pop_i   (pop0),
    .data_i  (data_in),
    .data_o  (data_out0),
    .valid_o (valid_out0),
    .full_o  (full0),
    .count_o (count0)
  );

  demux_vc_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo1 (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push1),
    .pop_i   (pop1),
    .data_i  (data_in),
    .data_o  (data_out1),
    .valid_o (valid_out1),
    .full_o  (full1),
    .count_o (count1)
  );

endmodule

// File: tb/tb_demux_vc.sv
module tb_demux_vc;

  localparam int DW    = 6;
  localparam int DEPTH = 4;
  localparam int SB    = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic [DW-1:0] data_out0;
  logic          valid_out0;
  logic          ready_in0 = 1'b0;
  logic [DW-1:0] data_out1;
  logic          valid_out1;
  logic          ready_in1 = 1'b0;
  logic [2:0]    count0;
  logic [2:0]    count1;

  demux_vc #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .SEL_BIT    (SB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out0  (data_out0),
    .valid_out0 (valid_out0),
    .ready_in0  (ready_in0),
    .data_out1  (data_out1),
    .valid_out1 (valid_out1),
    .ready_in1  (ready_in1),
    .count0     (count0),
    .count1     (count1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: two queues of words, one per channel.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] log1[$];
  int            max_c1 = 0;

  logic [DW-1:0] e_d0, e_d1;
  logic          e_ready, m_push, m_pop0, m_pop1;

  // Inputs change just after each rising edge, so at the falling edge they
  // are stable: compare, then advance the model to what the next edge does.
  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
    end
    e_d0    = (q0.size() > 0) ? q0[0] : '0;
    e_d1    = (q1.size() > 0) ? q1[0] : '0;
    e_ready = data_in[SB] ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    chk("ready_out",  {31'd0, ready_out},  {31'd0, e_ready});
    chk("valid_out0", {31'd0, valid_out0}, (q0.size() > 0) ? 32'd1 : 32'd0);
    chk("data_out0",  {26'd0, data_out0},  {26'd0, e_d0});
    chk("count0",     {29'd0, count0},     q0.size());
    chk("valid_out1", {31'd0, valid_out1}, (q1.size() > 0) ? 32'd1 : 32'd0);
    chk("data_out1",  {26'd0, data_out1},  {26'd0, e_d1});
    chk("count1",     {29'd0, count1},     q1.size());
    if (!reset) begin
      m_push = valid_in && e_ready;
      m_pop0 = (q0.size() > 0) && ready_in0;
      m_pop1 = (q1.size() > 0) && ready_in1;
      if (m_pop0) void'(q0.pop_front());
      if (m_pop1) log1.push_back(q1.pop_front());
      if (m_push) begin
        if (data_in[SB]) q1.push_back(data_in);
        else             q0.push_back(data_in);
      end
      if (q1.size() > max_c1) max_c1 = q1.size();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    valid_in = 1'b1;
    data_in  = w;
    step();
    valid_in = 1'b0;
  endtask

  logic acc;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count0", {29'd0, count0}, 0);
    chk("rst_valid0", {31'd0, valid_out0}, 0);
    chk("rst_data0",  {26'd0, data_out0}, 0);
    chk("rst_ready",  {31'd0, ready_out}, 1);
    reset = 1'b0;

    // Reset in the middle of traffic
    ready_in0 = 1'b0;
    push(6'h01); push(6'h02); push(6'h03);
    chk("mid_count0", {29'd0, count0}, 3);
    chk("mid_data0",  {26'd0, data_out0}, 6'h01);
    reset = 1'b1;
    #1;
    chk("async_count0", {29'd0, count0}, 0);
    chk("async_valid0", {31'd0, valid_out0}, 0);
    chk("async_data0",  {26'd0, data_out0}, 0);
    step();
    reset = 1'b0;
    push(6'h07);
    chk("post_rst_valid0", {31'd0, valid_out0}, 1);
    chk("post_rst_data0",  {26'd0, data_out0}, 6'h07);
    chk("post_rst_count0", {29'd0, count0}, 1);
    ready_in0 = 1'b1;
    step();
    chk("post_rst_drain", {31'd0, valid_out0}, 0);

    // Routing by bit 5
    ready_in1 = 1'b1;
    push(6'h05);
    chk("route_05", {26'd0, data_out0}, 6'h05);
    push(6'h25);
    chk("route_25", {26'd0, data_out1}, 6'h25);
    chk("route_v0_after25", {31'd0, valid_out0}, 0);
    push(6'h0A);
    chk("route_0A", {26'd0, data_out0}, 6'h0A);
    chk("route_v1_after0A", {31'd0, valid_out1}, 0);
    push(6'h3F);
    chk("route_3F", {26'd0, data_out1}, 6'h3F);
    chk("route_v0_after3F", {31'd0, valid_out0}, 0);
    step();
    chk("route_idle_v1", {31'd0, valid_out1}, 0);

    // Fill channel 0; channel 1 still accepts
    ready_in0 = 1'b0;
    ready_in1 = 1'b0;
    push(6'h01); push(6'h02); push(6'h03); push(6'h04);
    chk("full_count0", {29'd0, count0}, 4);
    valid_in = 1'b1;
    data_in  = 6'h06;
    #1;
    chk("full_ready_ch0", {31'd0, ready_out}, 0);
    data_in = 6'h20;
    #1;
    chk("full_ready_ch1", {31'd0, ready_out}, 1);
    step();
    chk("other_count1", {29'd0, count1}, 1);
    chk("other_data1",  {26'd0, data_out1}, 6'h20);
    chk("other_count0", {29'd0, count0}, 4);

    // Pop at full refuses the push in the same cycle
    ready_in0 = 1'b1;
    data_in   = 6'h08;
    #1;
    chk("popfull_ready", {31'd0, ready_out}, 0);
    step();
    chk("popfull_count0", {29'd0, count0}, 3);
    chk("popfull_head",   {26'd0, data_out0}, 6'h02);
    chk("popfull_ready2", {31'd0, ready_out}, 1);
    ready_in0 = 1'b0;
    step();
    chk("popfull_count0b", {29'd0, count0}, 4);
    valid_in = 1'b0;

    ready_in0 = 1'b1;
    ready_in1 = 1'b1;
    repeat (6) step();
    chk("drain_count0", {29'd0, count0}, 0);
    chk("drain_count1", {29'd0, count1}, 0);

    // Simultaneous push and pop on a non-full channel
    ready_in1 = 1'b0;
    push(6'h21); push(6'h22);
    chk("sim_count1a", {29'd0, count1}, 2);
    ready_in1 = 1'b1;
    push(6'h23);
    chk("sim_count1b", {29'd0, count1}, 2);
    chk("sim_head1",   {26'd0, data_out1}, 6'h22);
    step();
    chk("sim_head1b",  {26'd0, data_out1}, 6'h23);
    chk("sim_count1c", {29'd0, count1}, 1);
    step();
    chk("sim_count1d", {29'd0, count1}, 0);

    // Wrap-around on channel 1 with random backpressure
    log1.delete();
    max_c1 = 0;
    for (int i = 0; i < 12; i++) begin
      valid_in = 1'b1;
      data_in  = 6'h30 + 6'(i);
      acc = 1'b0;
      for (int t = 0; t < 50; t++) begin
        ready_in1 = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
        #1;
        acc = ready_out;
        @(posedge clk);
        #1;
        if (acc) break;
      end
      chk("wrap_accept", {31'd0, acc}, 1);
    end
    valid_in  = 1'b0;
    ready_in1 = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (count1 == 0) break;
      step();
    end
    chk("wrap_drain", {29'd0, count1}, 0);
    chk("wrap_nwords", log1.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < log1.size()) chk("wrap_word", {26'd0, log1[i]}, 32'h30 + i);
    end
    chk("wrap_maxcnt", (max_c1 <= DEPTH) ? 32'd1 : 32'd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
